// File: rtl/write_buffer.sv
// Posted-write buffer between the cache memory port (ram_*) and external RAM (mem_*).
// Writes are acked after one cycle and drained in the background; reads forward from the buffer.
module write_buffer #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] ram_address,
  input  logic                     ram_rd,
  input  logic                     ram_wr,
  input  logic [31:0]              ram_data_wr,
  output logic [31:0]              ram_data_rd,
  output logic                     ram_data_valid,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [31:0]              mem_data_wr,
  input  logic [31:0]              mem_data_rd,
  input  logic                     mem_data_valid,
  output logic                     wb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int WW = ADDRESS_WIDTH - 2;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, READ_WAIT = 2'd1, DRAIN_WAIT = 2'd2} state_t;

  state_t                   state_r;
  logic [WW-1:0]            addr_mem_r [DEPTH];
  logic [31:0]              data_mem_r [DEPTH];
  logic [PW-1:0]            rd_ptr_r;
  logic [PW-1:0]            wr_ptr_r;
  logic [PW:0]              count_r;
  logic                     pend_r;
  logic                     pend_rd_r;
  logic [ADDRESS_WIDTH-1:0] pend_addr_r;
  logic [31:0]              pend_data_r;

  logic                     cur_valid_s;
  logic                     cur_rd_s;
  logic [ADDRESS_WIDTH-1:0] cur_addr_s;
  logic [31:0]              cur_data_s;
  logic                     hit_s;
  logic [PW-1:0]            hit_idx_s;
  logic                     pop_s;
  logic                     ovr_s;
  logic                     push_s;
  logic                     rd_hit_s;
  logic                     rd_issue_s;
  logic [31:0]              head_data_s;

  // Select the request being serviced: a held one takes precedence over the ports.
  always_comb begin
    if (pend_r) begin
      cur_valid_s = 1'b1;
      cur_rd_s    = pend_rd_r;
      cur_addr_s  = pend_addr_r;
      cur_data_s  = pend_data_r;
    end else begin
      cur_valid_s = ram_rd | ram_wr;
      cur_rd_s    = ram_rd;
      cur_addr_s  = ram_address;
      cur_data_s  = ram_data_wr;
    end
  end

  // Youngest valid entry matching the request word address (scan oldest to youngest).
  always_comb begin
    logic [PW-1:0] idx_v;
    idx_v     = {PW{1'b0}};
    hit_s     = 1'b0;
    hit_idx_s = {PW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      idx_v = rd_ptr_r + PW'(k);
      if (((PW+1)'(k) < count_r) && (addr_mem_r[idx_v] == cur_addr_s[ADDRESS_WIDTH-1:2])) begin
        hit_s     = 1'b1;
        hit_idx_s = idx_v;
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // The head being written to RAM cannot be modified, so such a match allocates instead.
  assign pop_s      = (state_r == DRAIN_WAIT) && mem_data_valid;
  assign ovr_s      = cur_valid_s && !cur_rd_s && hit_s &&
                      !((state_r == DRAIN_WAIT) && (hit_idx_s == rd_ptr_r));
  assign push_s     = cur_valid_s && !cur_rd_s && !ovr_s && ((count_r != FULL_COUNT) || pop_s);
  assign rd_hit_s   = cur_valid_s && cur_rd_s && hit_s;
  assign rd_issue_s = cur_valid_s && cur_rd_s && !hit_s && (state_r == IDLE);
  // A drain launched in the same cycle as a head overwrite must carry the new data.
  assign head_data_s = (ovr_s && (hit_idx_s == rd_ptr_r)) ? cur_data_s : data_mem_r[rd_ptr_r];
  assign wb_empty    = (count_r == {(PW+1){1'b0}}) && (state_r == IDLE);

  // Upstream request handling, buffer storage and the downstream RAM FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      rd_ptr_r       <= {PW{1'b0}};
      wr_ptr_r       <= {PW{1'b0}};
      count_r        <= {(PW+1){1'b0}};
      pend_r         <= 1'b0;
      pend_rd_r      <= 1'b0;
      pend_addr_r    <= {ADDRESS_WIDTH{1'b0}};
      pend_data_r    <= 32'd0;
      ram_data_rd    <= 32'd0;
      ram_data_valid <= 1'b0;
      mem_address    <= {ADDRESS_WIDTH{1'b0}};
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_data_wr    <= 32'd0;
    end else begin
      ram_data_valid <= 1'b0;
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;

      if (rd_hit_s) begin
        ram_data_rd    <= data_mem_r[hit_idx_s];
        ram_data_valid <= 1'b1;
        pend_r         <= 1'b0;
      end else if (ovr_s) begin
        data_mem_r[hit_idx_s] <= cur_data_s;
        ram_data_valid        <= 1'b1;
        pend_r                <= 1'b0;
      end else if (push_s) begin
        addr_mem_r[wr_ptr_r] <= cur_addr_s[ADDRESS_WIDTH-1:2];
        data_mem_r[wr_ptr_r] <= cur_data_s;
        wr_ptr_r             <= wr_ptr_r + PW'(1);
        ram_data_valid       <= 1'b1;
        pend_r               <= 1'b0;
      end else if ((state_r == READ_WAIT) && mem_data_valid) begin
        ram_data_rd    <= mem_data_rd;
        ram_data_valid <= 1'b1;
        pend_r         <= 1'b0;
      end else if (cur_valid_s) begin
        pend_r      <= 1'b1;
        pend_rd_r   <= cur_rd_s;
        pend_addr_r <= cur_addr_s;
        pend_data_r <= cur_data_s;
      end else begin
        pend_r <= pend_r;
      end

      count_r <= count_r + (PW+1)'(push_s) - (PW+1)'(pop_s);

      case (state_r)
        IDLE: begin
          if (rd_issue_s) begin
            mem_rd      <= 1'b1;
            mem_address <= cur_addr_s;
            state_r     <= READ_WAIT;
          end else if (count_r != {(PW+1){1'b0}}) begin
            mem_wr      <= 1'b1;
            mem_address <= {addr_mem_r[rd_ptr_r], 2'b00};
            mem_data_wr <= head_data_s;
            state_r     <= DRAIN_WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        READ_WAIT: begin
          if (mem_data_valid) begin
            state_r <= IDLE;
          end else begin
            state_r <= READ_WAIT;
          end
        end
        DRAIN_WAIT: begin
          if (mem_data_valid) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
            state_r  <= IDLE;
          end else begin
            state_r <= DRAIN_WAIT;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: stimulus queues expected cache and RAM responses,
// negedge monitors pop and compare; a behavioural RAM with a stall control answers mem_*.
module tb_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ram_address;
  logic        ram_rd;
  logic        ram_wr;
  logic [31:0] ram_data_wr;
  logic [31:0] ram_data_rd;
  logic        ram_data_valid;
  logic [15:0] mem_address;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_data_wr;
  logic [31:0] mem_data_rd;
  logic        mem_data_valid;
  logic        wb_empty;

  write_buffer #(.ADDRESS_WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .ram_address(ram_address), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_data_wr(ram_data_wr), .ram_data_rd(ram_data_rd), .ram_data_valid(ram_data_valid),
    .mem_address(mem_address), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_wr(mem_data_wr), .mem_data_rd(mem_data_rd), .mem_data_valid(mem_data_valid),
    .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic rd; logic [31:0] d; } cache_exp_t;
  typedef struct packed { logic wr; logic [15:0] a; logic [31:0] d; } mem_exp_t;

  cache_exp_t  sb_q[$];
  mem_exp_t    mem_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  int          mdv_cyc = 0;
  logic        stall = 1'b0;
  logic [31:0] ram [16384];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  // Behavioural RAM: one completion per mem_rd/mem_wr, one cycle later unless stalled.
  initial begin
    logic [13:0] w;
    for (int i = 0; i < 16384; i++) ram[i] = {4{i[7:0]}};
    mem_data_valid = 1'b0;
    mem_data_rd    = 32'd0;
    forever begin
      @(posedge clk);
      if (mem_rd || mem_wr) begin
        w = mem_address[15:2];
        if (mem_wr) ram[w] = mem_data_wr;
        while (stall) @(posedge clk);
        #1;
        mem_data_valid = 1'b1;
        mem_data_rd    = ram[w];
        mdv_cyc        = cyc;
        @(posedge clk);
        #1;
        mem_data_valid = 1'b0;
      end
    end
  end

  // Monitors: every cache completion and every RAM command must match the next expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_data_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ram_data_valid", 32'd1, 32'd0);
        end else begin
          cache_exp_t e;
          e = sb_q.pop_front();
          if (e.rd) chk("ram_data_rd", ram_data_rd, e.d);
        end
      end
      if (mem_rd || mem_wr) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_cmd", {16'd0, mem_address}, 32'hFFFF_FFFF);
        end else begin
          mem_exp_t m;
          m = mem_q.pop_front();
          chk("mem_kind_is_wr", {31'd0, mem_wr}, {31'd0, m.wr});
          chk("mem_address", {16'd0, mem_address}, {16'd0, m.a});
          if (m.wr) chk("mem_data_wr", mem_data_wr, m.d);
        end
      end
    end
  end

  // Issue one cache request (called just after a clock edge); lat = cycles until ram_data_valid.
  task automatic req(input logic rd, input logic [15:0] a, input logic [31:0] d, output int lat);
    ram_rd      = rd;
    ram_wr      = !rd;
    ram_address = a;
    ram_data_wr = d;
    @(posedge clk);
    #1;
    ram_rd = 1'b0;
    ram_wr = 1'b0;
    lat    = 1;
    while (!ram_data_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    while (!wb_empty && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, {31'd0, wb_empty}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int ack_cyc;
    rst = 1'b1; ram_rd = 1'b0; ram_wr = 1'b0; ram_address = 16'd0; ram_data_wr = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_wb_empty", {31'd0, wb_empty}, 32'd1);
    chk("reset_ram_data_valid", {31'd0, ram_data_valid}, 32'd0);
    chk("reset_mem_cmd", {30'd0, mem_rd, mem_wr}, 32'd0);

    // 1: single write, acked next cycle, drained once, buffer empties
    sb_q.push_back('{1'b0, 32'd0});
    mem_q.push_back('{1'b1, 16'hD030, 32'h0000_1234});
    req(1'b0, 16'hD030, 32'h0000_1234, lat);
    chk("t1_ack_latency", lat, 32'd1);
    chk("t1_not_empty_after_ack", {31'd0, wb_empty}, 32'd0);
    wait_empty("t1_wb_empty");
    chk("t1_ram_contents", ram[16'hD030 >> 2], 32'h0000_1234);

    // 2: write then immediate read of the same word is forwarded, no mem_rd
    sb_q.push_back('{1'b0, 32'd0});
    mem_q.push_back('{1'b1, 16'hD030, 32'h0000_1234});
    req(1'b0, 16'hD030, 32'h0000_1234, lat);
    sb_q.push_back('{1'b1, 32'h0000_1234});
    req(1'b1, 16'hD030, 32'd0, lat);
    chk("t2_read_hit_latency", lat, 32'd1);
    wait_empty("t2_wb_empty");

    // 3: read miss on empty buffer goes to RAM
    mem_q.push_back('{1'b0, 16'h0020, 32'd0});
    sb_q.push_back('{1'b1, 32'h0808_0808});
    req(1'b1, 16'h0020, 32'd0, lat);
    chk("t3_read_miss_latency", lat, 32'd3);
    wait_empty("t3_wb_empty");

    // 4: stalled RAM, four writes fill the buffer, fifth waits for the first pop
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{1'b0, 32'd0});
      mem_q.push_back('{1'b1, 16'(i * 4), {4{8'h11 * 8'(i + 1)}}});
    end
    for (int i = 0; i < 4; i++) begin
      req(1'b0, 16'(i * 4), {4{8'h11 * 8'(i + 1)}}, lat);
      chk("t4_fill_ack_latency", lat, 32'd1);
    end
    fork
      begin
        req(1'b0, 16'h0010, 32'h5555_5555, lat);
        ack_cyc = cyc;
      end
      begin
        repeat (6) @(posedge clk);
        #1 stall = 1'b0;
      end
    join
    chk("t4_full_write_held", {31'd0, lat > 1}, 32'd1);
    chk("t4_ack_after_pop", ack_cyc, mdv_cyc + 1);
    wait_empty("t4_wb_empty");
    chk("t4_ram_last", ram[4], 32'h5555_5555);

    // 5: same-word writes while RAM is stalled coalesce into one drain of the newer data
    stall = 1'b1;
    sb_q.push_back('{1'b0, 32'd0});
    sb_q.push_back('{1'b0, 32'd0});
    mem_q.push_back('{1'b1, 16'h0040, 32'h0000_BBBB});
    req(1'b0, 16'h0040, 32'h0000_AAAA, lat);
    req(1'b0, 16'h0040, 32'h0000_BBBB, lat);
    chk("t5_second_ack_latency", lat, 32'd1);
    repeat (4) @(posedge clk);
    #1 stall = 1'b0;
    wait_empty("t5_wb_empty");
    repeat (4) @(posedge clk);
    #1;
    chk("t5_ram_final", ram[16'h0040 >> 2], 32'h0000_BBBB);

    // 6: reset while a drain is outstanding, then a late completion is ignored
    stall = 1'b1;
    sb_q.push_back('{1'b0, 32'd0});
    mem_q.push_back('{1'b1, 16'h0080, 32'hCAFE_F00D});
    req(1'b0, 16'h0080, 32'hCAFE_F00D, lat);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_wb_empty", {31'd0, wb_empty}, 32'd1);
    chk("t6_mem_cmd", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("t6_ram_data_valid", {31'd0, ram_data_valid}, 32'd0);
    chk("t6_ram_data_rd", ram_data_rd, 32'd0);
    chk("t6_mem_address", {16'd0, mem_address}, 32'd0);
    chk("t6_mem_data_wr", mem_data_wr, 32'd0);
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t6_late_valid_ignored", {30'd0, wb_empty, ram_data_valid}, 32'd2);
    end

    chk("final_cache_queue_drained", sb_q.size(), 32'd0);
    chk("final_mem_queue_drained", mem_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
